mult_seq_ctrl: RTL and testbench
================================

Name: mult_seq_ctrl

Overview:
- Multi-cycle sequencer between the EX stage and a shared pipelined unsigned 32x32 multiplier core.
- Captures one multiply-class op and converts operands to magnitudes for the core.
- Holds the pipeline stalled for the core latency, then applies sign correction and HI/LO accumulate/subtract.
- Issues a single-cycle HI/LO write (or GPR write for MUL); squashes in-flight ops on flush.

Parameters:
- MUL_LATENCY, 3, cycles from operands presented on mult_a/mult_b to a valid mult_product (must be >= 1)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- start  in  1  EX holds a valid multiply-class op this cycle
- op  in  3  0=MULTU 1=MULT 2=MUL 3=MADD 4=MADDU 5=MSUB 6=MSUBU; 7 treated as MULTU
- operand_1  in  32  rs value
- operand_2  in  32  rt value
- hi_in  in  32  forwarded HI, sampled in the DONE cycle
- lo_in  in  32  forwarded LO, sampled in the DONE cycle
- flush  in  1  pipeline flush (exception/eret)
- mult_a  out  32  magnitude operand A to multiplier core
- mult_b  out  32  magnitude operand B to multiplier core
- mult_product  in  64  unsigned core product
- stall_req  out  1  stall request to pipeline control
- result  out  64  final {hi,lo} value, or {32'x, gpr} for MUL
- hilo_we  out  1  single-cycle HI/LO write strobe
- gpr_we  out  1  single-cycle GPR write strobe (MUL only); result[31:0] is the data
- busy  out  1  state != IDLE

Behaviour:
- Reset values: state=IDLE; mult_a, mult_b, result = 0; stall_req, hilo_we, gpr_we, busy = 0; counter=0.
- Signed ops: MULT, MUL, MADD, MSUB. All others unsigned.
- Operand capture:
  - For signed ops, a negative operand is replaced by its two's complement magnitude; unsigned ops pass operands as-is.
  - neg_flag = op1[31]^op2[31] for signed ops, 0 otherwise.
  - op, neg_flag and magnitudes are registered.
- FSM states: IDLE, BUSY, DONE.
  - IDLE:
    - stall_req = start & ~flush (combinational, so EX stalls in the issue cycle).
    - On start & ~flush: register magnitudes onto mult_a/mult_b, counter<=MUL_LATENCY-1, go BUSY.
  - BUSY:
    - stall_req=1.
    - Counter decrements each cycle; when counter==0, go DONE.
  - DONE:
    - stall_req=0, so EX advances this cycle.
    - p = neg_flag ? -mult_product : mult_product (64-bit two's complement).
    - MULT/MULTU/MUL: r=p.
    - MADD/MADDU: r={hi_in,lo_in}+p.
    - MSUB/MSUBU: r={hi_in,lo_in}-p.
    - All arithmetic is modulo 2^64.
    - result<=r (registered, valid in the cycle after DONE alongside the strobes).
    - hilo_we=1 for every op except MUL; gpr_we=1 for MUL only.
    - Next state is IDLE.
- Timing:
  - start sampled at cycle 0; DONE at cycle MUL_LATENCY+1; strobes visible at cycle MUL_LATENCY+2.
  - Strobes last exactly 1 cycle.
- mult_a/mult_b hold their value from capture until the next capture.
- start while BUSY/DONE is ignored (EX is stalled, so it shows the same op); a new op is accepted only from IDLE.
- Back-to-back: a new start in the cycle after DONE is accepted normally.
- Flush:
  - flush in any state: next state IDLE, no strobe, any pending result discarded; result holds its previous value.
  - flush concurrent with start in IDLE: op not accepted.
- rst mid-operation: all outputs return to reset values next cycle; no write occurs.

Optional Feature:
- MULT_ZERO_BYPASS_EN
  - Defined: in IDLE, if start & ~flush and either operand is 0, go directly to DONE with p forced to 0, bypassing BUSY; mult_product is ignored.
  - Defined: latency is 1 cycle to DONE, and stall_req is asserted only in the issue cycle.
  - Undefined: zero operands take the full MUL_LATENCY path; behaviour otherwise identical.

Test Plan:
- MULT -3 x 5, latency 3 -> mult_a=3, mult_b=5; stall_req high cycles 0-3; at cycle 5: hilo_we=1, result=0xFFFFFFFF_FFFFFFF1.
- MULTU 0xFFFFFFFF x 2 -> result=0x00000001_FFFFFFFE, hilo_we=1, gpr_we=0.
- MADD 2 x -4, hi_in=0, lo_in=10 -> result=0x00000000_00000002. MSUBU 3 x 3, hi_in=0, lo_in=5 -> result=0xFFFFFFFF_FFFFFFFC.
- MUL -7 x -6 -> gpr_we=1, result[31:0]=42, hilo_we=0.
- flush asserted in second BUSY cycle -> next cycle IDLE, stall_req=0, no strobe for the following 5 cycles; a later start completes normally.
- With MULT_ZERO_BYPASS_EN defined: MULT 0 x 0x1234 -> DONE at cycle 1, result=0; without the macro -> DONE at cycle 4.

Source files
------------

// File: rtl/mult_seq_ctrl.sv
// Sequencer between EX and a shared pipelined unsigned 32x32 multiplier: captures an op,
// stalls for the core latency, then sign-corrects and accumulates. Optional: MULT_ZERO_BYPASS_EN.
module mult_seq_ctrl #(
  parameter int MUL_LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] operand_1,
  input  logic [31:0] operand_2,
  input  logic [31:0] hi_in,
  input  logic [31:0] lo_in,
  input  logic        flush,
  output logic [31:0] mult_a,
  output logic [31:0] mult_b,
  input  logic [63:0] mult_product,
  output logic        stall_req,
  output logic [63:0] result,
  output logic        hilo_we,
  output logic        gpr_we,
  output logic        busy
);

  localparam int CW = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(MUL_LATENCY - 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MUL   = 3'd2;
  localparam logic [2:0] OP_MADD  = 3'd3;
  localparam logic [2:0] OP_MADDU = 3'd4;
  localparam logic [2:0] OP_MSUB  = 3'd5;
  localparam logic [2:0] OP_MSUBU = 3'd6;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] counter_reg;
  logic [2:0]    op_reg;
  logic          neg_reg;
  logic          signed_op;
  logic          accept;
  logic [31:0]   mag_1, mag_2;
  logic [63:0]   p, r;
`ifdef MULT_ZERO_BYPASS_EN
  logic          zero_in;
  logic          zero_reg;
`endif

  always_comb begin
    signed_op = (op == OP_MULT) || (op == OP_MUL) || (op == OP_MADD) || (op == OP_MSUB);
    mag_1     = (signed_op && operand_1[31]) ? (~operand_1 + 32'd1) : operand_1;
    mag_2     = (signed_op && operand_2[31]) ? (~operand_2 + 32'd1) : operand_2;
    accept    = (state_reg == IDLE) && start && !flush;
`ifdef MULT_ZERO_BYPASS_EN
    zero_in   = (operand_1 == 32'd0) || (operand_2 == 32'd0);
`endif
  end

  always_comb begin
    state_next = state_reg;
    stall_req  = 1'b0;
    case (state_reg)
      IDLE: begin
        stall_req = start && !flush;
        if (accept) begin
`ifdef MULT_ZERO_BYPASS_EN
          state_next = zero_in ? DONE : BUSY;
`else
          state_next = BUSY;
`endif
        end
      end
      BUSY: begin
        stall_req = 1'b1;
        if (counter_reg == '0) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  // Sign correction on the unsigned core product, then optional HI/LO accumulate.
  always_comb begin
    p = neg_reg ? (~mult_product + 64'd1) : mult_product;
`ifdef MULT_ZERO_BYPASS_EN
    if (zero_reg) p = 64'd0;
`endif
    case (op_reg)
      OP_MADD, OP_MADDU: r = {hi_in, lo_in} + p;
      OP_MSUB, OP_MSUBU: r = {hi_in, lo_in} - p;
      default:           r = p;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      counter_reg <= '0;
      op_reg      <= 3'd0;
      neg_reg     <= 1'b0;
      mult_a      <= 32'd0;
      mult_b      <= 32'd0;
      result      <= 64'd0;
      hilo_we     <= 1'b0;
      gpr_we      <= 1'b0;
`ifdef MULT_ZERO_BYPASS_EN
      zero_reg    <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      hilo_we   <= 1'b0;
      gpr_we    <= 1'b0;
      if (accept) begin
        mult_a      <= mag_1;
        mult_b      <= mag_2;
        op_reg      <= op;
        neg_reg     <= signed_op && (operand_1[31] ^ operand_2[31]);
        counter_reg <= CNT_INIT;
`ifdef MULT_ZERO_BYPASS_EN
        zero_reg    <= zero_in;
`endif
      end else if (state_reg == BUSY && counter_reg != '0) begin
        counter_reg <= counter_reg - CW'(1);
      end
      if (state_reg == DONE && !flush) begin
        result  <= r;
        hilo_we <= (op_reg != OP_MUL);
        gpr_we  <= (op_reg == OP_MUL);
      end
    end
  end

  assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Scoreboard bench for mult_seq_ctrl: directed ops push expected results, a monitor
// checks every HI/LO or GPR write strobe against the queue.
module tb_mult_seq_ctrl;
  localparam int L = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] operand_1 = 32'd0, operand_2 = 32'd0, hi_in = 32'd0, lo_in = 32'd0;
  logic        flush = 1'b0;
  logic [31:0] mult_a, mult_b;
  logic [63:0] mult_product;
  logic        stall_req, hilo_we, gpr_we, busy;
  logic [63:0] result;

  typedef struct {
    logic [63:0] res;
    bit          mul;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic [63:0] last_res = 64'd0;
  logic [63:0] pipe [0:L-1];

  mult_seq_ctrl #(.MUL_LATENCY(L)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .operand_1(operand_1), .operand_2(operand_2), .hi_in(hi_in), .lo_in(lo_in),
    .flush(flush), .mult_a(mult_a), .mult_b(mult_b), .mult_product(mult_product),
    .stall_req(stall_req), .result(result), .hilo_we(hilo_we), .gpr_we(gpr_we),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pipelined unsigned multiplier core model, L register stages.
  always @(posedge clk) begin
    pipe[0] <= {32'd0, mult_a} * {32'd0, mult_b};
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign mult_product = pipe[L-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (hilo_we || gpr_we) begin
        if (sb.size() == 0) begin
          check("unexpected_strobe", {62'd0, hilo_we, gpr_we}, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (e.mul) check("gpr_data", {32'd0, result[31:0]}, {32'd0, e.res[31:0]});
          else       check("hilo_data", result, e.res);
          check("hilo_we", {63'd0, hilo_we}, {63'd0, !e.mul});
          check("gpr_we", {63'd0, gpr_we}, {63'd0, e.mul});
          check("strobe_cycle", 64'(cyc), 64'(e.cyc));
          $display("txn cycle=%0d result=%h hilo_we=%0b gpr_we=%0b", cyc, result, hilo_we, gpr_we);
        end
      end
    end
  end

  // Called one time unit after a rising edge; returns in the same phase after
  // the op has left the sequencer.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] h, input logic [31:0] l,
                        input logic [31:0] ea, input logic [31:0] eb, input logic [63:0] er);
    exp_t e;
    bit   byp;
    int   stalls, busies;
    bit   done;
`ifdef MULT_ZERO_BYPASS_EN
    byp = (a == 32'd0) || (b == 32'd0);
`else
    byp = 1'b0;
`endif
    start = 1'b1; op = o; operand_1 = a; operand_2 = b; hi_in = h; lo_in = l;
    #0;
    check("stall_issue", {63'd0, stall_req}, 64'd1);
    e.res = er; e.mul = (o == 3'd2); e.cyc = cyc + (byp ? 2 : L + 2);
    sb.push_back(e);
    stalls = 1; busies = 0; done = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        check("mult_a", {32'd0, mult_a}, {32'd0, ea});
        check("mult_b", {32'd0, mult_b}, {32'd0, eb});
      end
      if (!busy) begin
        done = 1'b1;
        break;
      end
      busies++;
      if (stall_req) stalls++;
    end
    start = 1'b0;
    if (!done) check("op_timeout", 64'd1, 64'd0);
    check("stall_cycles", 64'(stalls), 64'(byp ? 1 : L + 1));
    check("busy_cycles", 64'(busies), 64'(byp ? 1 : L + 1));
    last_res = er;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_mult_a", {32'd0, mult_a}, 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_ctrl", {60'd0, stall_req, hilo_we, gpr_we, busy}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(3'd1, 32'hFFFFFFFD, 32'd5,        32'd0, 32'd0,  32'd3, 32'd5, 64'hFFFFFFFF_FFFFFFF1);
    run_op(3'd0, 32'hFFFFFFFF, 32'd2,        32'd0, 32'd0,  32'hFFFFFFFF, 32'd2, 64'h00000001_FFFFFFFE);
    run_op(3'd3, 32'd2,        32'hFFFFFFFC, 32'd0, 32'd10, 32'd2, 32'd4, 64'h00000000_00000002);
    run_op(3'd6, 32'd3,        32'd3,        32'd0, 32'd5,  32'd3, 32'd3, 64'hFFFFFFFF_FFFFFFFC);
    run_op(3'd2, 32'hFFFFFFF9, 32'hFFFFFFFA, 32'd0, 32'd0,  32'd7, 32'd6, 64'h00000000_0000002A);
    run_op(3'd5, 32'd1,        32'hFFFFFFFF, 32'd0, 32'd0,  32'd1, 32'd1, 64'h00000000_00000001);
    run_op(3'd4, 32'h80000000, 32'd2,        32'd1, 32'd0,  32'h80000000, 32'd2, 64'h00000002_00000000);
    run_op(3'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0,  32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
    run_op(3'd1, 32'h80000000, 32'd1,        32'd0, 32'd0,  32'h80000000, 32'd1, 64'hFFFFFFFF_80000000);
    run_op(3'd1, 32'd0,        32'h1234,     32'd0, 32'd0,  32'd0, 32'h1234, 64'd0);
    run_op(3'd6, 32'h10,       32'd0,        32'd0, 32'h20, 32'h10, 32'd0, 64'h00000000_00000020);
    run_op(3'd4, 32'd1,        32'd1,        32'd0, 32'hFFFFFFFF, 32'd1, 32'd1, 64'h00000001_00000000);

    // Flush in the second BUSY cycle squashes the op.
    @(posedge clk); #1;
    start = 1'b1; op = 3'd1; operand_1 = 32'd6; operand_2 = 32'd7;
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    #0;
    check("flush_idle", {62'd0, busy, stall_req}, 64'd0);
    repeat (5) @(posedge clk);
    #1;
    check("flush_result_hold", result, last_res);

    // Flush together with start in IDLE: op refused.
    start = 1'b1; flush = 1'b1; op = 3'd0; operand_1 = 32'd9; operand_2 = 32'd9;
    #0;
    check("flush_start_stall", {63'd0, stall_req}, 64'd0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    #0;
    check("flush_start_busy", {63'd0, busy}, 64'd0);
    repeat (4) @(posedge clk);
    #1;
    run_op(3'd0, 32'd6, 32'd7, 32'd0, 32'd0, 32'd6, 32'd7, 64'd42);

    // Reset in the middle of an op: outputs clear, no write follows.
    start = 1'b1; op = 3'd3; operand_1 = 32'd5; operand_2 = 32'd5; hi_in = 32'd1; lo_in = 32'd1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    check("midrst_ops", {mult_a, mult_b}, 64'd0);
    check("midrst_result", result, 64'd0);
    check("midrst_ctrl", {60'd0, stall_req, hilo_we, gpr_we, busy}, 64'd0);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    run_op(3'd2, 32'd3, 32'hFFFFFFFE, 32'd0, 32'd0, 32'd3, 32'd2, 64'h00000000_FFFFFFFA);

    repeat (4) @(posedge clk);
    #1;
    check("queue_drain", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
